// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 brute-force key search:
// controller state encoding, plaintext character bounds and key width.
package ksa_pkg;

    localparam int KEY_W = 24;

    localparam logic [7:0] ASCII_LO = 8'h61;
    localparam logic [7:0] ASCII_HI = 8'h7A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_RC4 = 3'd2,
        SCAN     = 3'd3,
        DECIDE   = 3'd4,
        NEXT_KEY = 3'd5,
        FOUND    = 3'd6,
        FAIL     = 3'd7
    } cracker_state_t;

    // A candidate plaintext may contain only lowercase letters and spaces.
    function automatic logic is_plain_byte(input logic [7:0] b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
    endfunction

endpackage

// File: rtl/key_cracker_scan.sv
// Decrypted-message scanner: walks DM addresses 0..MSG_LEN-1 while go_i is high,
// checks each byte on its return cycle and keeps a running all-valid flag.
module key_cracker_scan
    import ksa_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go_i,
    input  logic [7:0] dm_rddata_i,
    output logic [7:0] addr_o,
    output logic       done_o,
    output logic       ok_o,
    output logic       abort_o
);

    localparam int               CNT_W     = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(MSG_LEN);
    localparam logic [7:0]       LAST_ADDR = 8'(MSG_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             all_ok_q, all_ok_d;
    logic             issue;
    logic             byte_ok;

    assign issue   = go_i && (cnt_q != CNT_END);
    assign byte_ok = is_plain_byte(dm_rddata_i);

    // Dropping go_i re-arms the scanner, so every SCAN entry starts at address 0
    // with all_ok set and nothing in flight.
    always_comb begin
        cnt_d    = cnt_q;
        pend_d   = 1'b0;
        all_ok_d = all_ok_q;
        if (!go_i) begin
            cnt_d    = '0;
            all_ok_d = 1'b1;
        end else begin
            pend_d = issue;
            if (issue) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (pend_q && !byte_ok) begin
                all_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            all_ok_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            all_ok_q <= all_ok_d;
        end
    end

    // The last address is held through the data-latency cycle.
    assign addr_o  = (cnt_q != CNT_END) ? 8'(cnt_q) : LAST_ADDR;
    assign done_o  = go_i && pend_q && !issue;
    assign ok_o    = all_ok_q;
    assign abort_o = go_i && pend_q && !byte_ok;

endmodule

// File: rtl/key_cracker.sv
// Brute-force RC4 key search controller: launches the RC4 chain per candidate,
// scans the decrypted message and stops on a plaintext hit. Build option:
// KEY_CRACKER_EARLY_ABORT_EN ends a scan at the first invalid byte.
module key_cracker
    import ksa_pkg::*;
#(
    parameter int               MSG_LEN   = 32,
    parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic [KEY_W-1:0] key,
    output logic             rc4_start,
    input  logic             rc4_done,
    output logic             dm_sel,
    output logic [7:0]       dm_addr,
    input  logic [7:0]       dm_rddata,
    output logic             busy,
    output logic             found,
    output logic             failed
);

    cracker_state_t   state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             done_q;
    logic             done_rise;

    logic             scan_go;
    logic [7:0]       scan_addr;
    logic             scan_done;
    logic             scan_ok;
    logic             scan_abort;
    logic             scan_end;

    // Only a fresh rising edge of the decrypt flag counts; a level left over
    // from the previous run is ignored.
    assign done_rise = rc4_done && !done_q;
    assign scan_go   = (state_q == SCAN);

    key_cracker_scan #(
        .MSG_LEN(MSG_LEN)
    ) u_scan (
        .clk        (clk),
        .reset_n    (reset_n),
        .go_i       (scan_go),
        .dm_rddata_i(dm_rddata),
        .addr_o     (scan_addr),
        .done_o     (scan_done),
        .ok_o       (scan_ok),
        .abort_o    (scan_abort)
    );

`ifdef KEY_CRACKER_EARLY_ABORT_EN
    assign scan_end = scan_done || scan_abort;
`else
    logic unused_scan_abort;
    assign unused_scan_abort = scan_abort;
    assign scan_end          = scan_done;
`endif

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_RC4;
            end
            WAIT_RC4: begin
                if (done_rise) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scan_end) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                state_d = scan_ok ? FOUND : NEXT_KEY;
            end
            NEXT_KEY: begin
                // The range ends at KEY_MAX; the counter never wraps.
                if (key_q == KEY_MAX) begin
                    state_d = FAIL;
                end else begin
                    key_d   = key_q + KEY_W'(1);
                    state_d = LAUNCH;
                end
            end
            FOUND: begin
                state_d = FOUND;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            key_q   <= KEY_START;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            done_q  <= rc4_done;
        end
    end

    // Outputs decode straight from state so dm_sel drops the cycle SCAN is left.
    assign key       = key_q;
    assign rc4_start = (state_q == LAUNCH);
    assign dm_sel    = scan_go;
    assign dm_addr   = dm_sel ? scan_addr : 8'h00;
    assign busy      = (state_q != IDLE) && (state_q != FOUND) && (state_q != FAIL);
    assign found     = (state_q == FOUND);
    assign failed    = (state_q == FAIL);

endmodule

// File: doc/key_cracker.md
# key_cracker

Brute-force key-search controller that sits directly upstream of the RC4 chain (init loop → swap loop → decrypt loop). It drives the 24-bit key, restarts the chain for each candidate, and waits for decryption to complete. It then scans the decrypted-message memory (DM) for plaintext validity and either stops with the winning key or advances to the next candidate. At the top level it replaces the constant key and takes over the DM read port between decrypt runs.

## Interface
Parameters:
- MSG_LEN, 32: bytes of DM scanned per candidate (1..256).
- KEY_START, 24'h000000: first candidate key.
- KEY_MAX, 24'h3FFFFF: last candidate key; upper 2 key bits are always zero.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous, active-low reset (KEY[3]).
- start  in  1  level; search begins on the first clk edge where it is high in IDLE.
- key  out  24  current candidate; feeds the swap loop key input.
- rc4_start  out  1  one-cycle pulse that restarts the RC4 chain with `key`.
- rc4_done  in  1  decrypt-loop done flag (level); only its rising edge is used.
- dm_sel  out  1  high while the cracker owns the DM address port.
- dm_addr  out  8  DM read address.
- dm_rddata  in  8  DM q; valid 1 cycle after dm_addr.
- busy  out  1  high in every state except IDLE, FOUND and FAIL.
- found  out  1  sticky; high in FOUND.
- failed  out  1  sticky; high in FAIL.

## Operation
- States: IDLE, LAUNCH, WAIT_RC4, SCAN, DECIDE, NEXT_KEY, FOUND, FAIL.
- IDLE: key=KEY_START. `start` high → LAUNCH.
- LAUNCH: rc4_start=1 for exactly one cycle → WAIT_RC4.
- WAIT_RC4: rc4_done is registered internally. Rising edge (prev=0, now=1) → SCAN. A done level already high on entry is ignored.
- SCAN: dm_sel=1. dm_addr steps 0..MSG_LEN-1, one address per cycle. Each returned byte is checked one cycle later.
- Valid byte: 8'h61..8'h7A ('a'..'z') or 8'h20 (space). Any other byte clears the internal `all_ok` flag. `all_ok` is set at SCAN entry.
- DECIDE: all_ok=1 → FOUND; else NEXT_KEY.
- NEXT_KEY: if key==KEY_MAX → FAIL; else key=key+1, then → LAUNCH. No wrap-around ever occurs.
- FOUND / FAIL: terminal. key is held, dm_sel=0. They exit only on reset.
- `start` outside IDLE is ignored.
- key changes only in NEXT_KEY and reset. It is stable from LAUNCH through DECIDE.

## Timing
- Reset values: key=KEY_START, rc4_start=0, dm_sel=0, dm_addr=0, busy=0, found=0, failed=0, state=IDLE.
- Asynchronous reset mid-search returns to IDLE immediately. No partial result is retained.
- start→rc4_start: 1 cycle (IDLE→LAUNCH edge). rc4_start is high in the cycle after start is sampled.
- rc4_done rising edge → first dm_addr (0) is presented in the next cycle.
- Full scan: MSG_LEN address cycles + 1 data-latency cycle, then 1 DECIDE cycle.
- found/failed assert in the cycle after DECIDE / NEXT_KEY respectively.
- dm_sel deasserts in the same cycle the state leaves SCAN, so the decrypt loop regains DM before the next rc4_start.
- rc4_start and dm_sel are never high in the same cycle.

## Configuration
- KEY_CRACKER_EARLY_ABORT_EN defined: the first invalid byte ends SCAN, going to DECIDE on the cycle after that byte returns. Addresses already in flight are discarded.
- Not defined: every candidate scans all MSG_LEN bytes, giving a fixed per-candidate scan latency (MSG_LEN+2 cycles).
- The result (found key) is identical in both builds.

## Structure
- ksa_pkg holds:
  - the state enum `cracker_state_t`;
  - the constants ASCII_LO=8'h61, ASCII_HI=8'h7A, ASCII_SP=8'h20;
  - KEY_W=24.
- Sub-module key_cracker_scan:
  - owns the address counter, 1-cycle data alignment, validity check and all_ok;
  - interface: go / done / ok / abort.
- The top module keeps the FSM and key register.
- The DM address mux at the top level is driven by dm_sel.

## Test plan
- Reset, then start=1; the chain stub raises rc4_done 50 cycles after rc4_start. Expect: rc4_start 1 cycle after start; key=0; dm_addr 0..31 after the done edge.
- DM stub returns 'x' (8'h78) for all bytes only when key==24'h000249, else 8'h00 at addr 5. Expect: found=1, key=24'h000249, busy=0; 586 rc4_start pulses in total.
- KEY_START=24'h3FFFFE, DM always invalid. Expect: two candidates tried, failed=1, key=24'h3FFFFF, no wrap to 0.
- rc4_done held high from reset through start. Expect: no scan until done falls and rises again after rc4_start.
- reset_n low while in SCAN at dm_addr=10. Expect: all outputs at reset values the same cycle; restart from key=KEY_START.
- Byte 8'h7B at addr 0. With KEY_CRACKER_EARLY_ABORT_EN: NEXT_KEY 2 cycles after addr 0. Without: after addr 31 plus 2 cycles.
